// File: rtl/prim_onehot_rr_arb.sv
// prim_onehot_rr_arb: round-robin arbiter with a one-hot grant, a binary grant
// index, a selected data word and a valid/ready output handshake.
// A grant offered while downstream stalls is locked until it is accepted, so
// the grant, index and selected requester stay stable across backpressure.
// Optional macro PRIM_ONEHOT_RR_ARB_ASSERT_EN compiles in SVA protocol checks.
module prim_onehot_rr_arb #(
    parameter int unsigned Width  = 32,
    parameter int unsigned Inputs = 8,
    localparam int unsigned IdxW  = $clog2(Inputs)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [Inputs-1:0]   req_i,
    input  logic [Width-1:0]    data_i [Inputs],
    output logic [Inputs-1:0]   gnt_o,
    output logic [IdxW-1:0]     idx_o,
    output logic                valid_o,
    input  logic                ready_i,
    output logic [Width-1:0]    data_o
);

    localparam logic UNLOCKED = 1'b0;
    localparam logic LOCKED   = 1'b1;

    logic                lock_q, lock_d;
    logic [Inputs-1:0]   lock_gnt_q, lock_gnt_d;
    logic [IdxW-1:0]     ptr_q, ptr_d;

    logic [Inputs-1:0]   rr_gnt;
    logic                rr_found;
    logic [IdxW:0]       rr_pos;
    logic                hs;

    // Rotating-priority search: first set request at or after ptr_q, wrapping at Inputs.
    // rr_pos is one bit wider than the index so ptr_q + k cannot overflow before the wrap.
    always_comb begin
        rr_gnt   = '0;
        rr_found = 1'b0;
        rr_pos   = '0;
        for (int unsigned k = 0; k < Inputs; k++) begin
            rr_pos = {1'b0, ptr_q} + (IdxW+1)'(k);
            if (rr_pos >= (IdxW+1)'(Inputs)) begin
                rr_pos = rr_pos - (IdxW+1)'(Inputs);
            end
            if (!rr_found && req_i[rr_pos[IdxW-1:0]]) begin
                rr_gnt[rr_pos[IdxW-1:0]] = 1'b1;
                rr_found                 = 1'b1;
            end
        end
    end

    // Outputs: locked grant wins over the live search; ready_i is not used here.
    always_comb begin
        gnt_o   = (lock_q == LOCKED) ? lock_gnt_q : rr_gnt;
        valid_o = (lock_q == LOCKED) ? 1'b1 : (|req_i);
        idx_o   = '0;
        for (int unsigned i = 0; i < Inputs; i++) begin
            if (gnt_o[i]) begin
                idx_o = IdxW'(i);
            end
        end
        data_o  = valid_o ? data_i[idx_o] : '0;
    end

    assign hs = valid_o && ready_i;

    // Next lock state: lock on a stalled offer, release on the handshake.
    always_comb begin
        lock_d = lock_q;
        case (lock_q)
            UNLOCKED: if (valid_o && !ready_i) lock_d = LOCKED;
            LOCKED:   if (ready_i)             lock_d = UNLOCKED;
            default:  lock_d = UNLOCKED;
        endcase
    end

    // Next grant capture and pointer: pointer moves just past the accepted requester.
    always_comb begin
        lock_gnt_d = lock_gnt_q;
        ptr_d      = ptr_q;
        if ((lock_q == UNLOCKED) && valid_o && !ready_i) begin
            lock_gnt_d = gnt_o;
        end
        if (hs) begin
            ptr_d = (idx_o == IdxW'(Inputs-1)) ? '0 : idx_o + IdxW'(1);
        end
    end

    // State registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q     <= UNLOCKED;
            lock_gnt_q <= '0;
            ptr_q      <= '0;
        end else begin
            lock_q     <= lock_d;
            lock_gnt_q <= lock_gnt_d;
            ptr_q      <= ptr_d;
        end
    end

`ifdef PRIM_ONEHOT_RR_ARB_ASSERT_EN
    if (Inputs < 2) begin : g_inputs_chk
        $error("prim_onehot_rr_arb: Inputs must be >= 2");
    end

    a_gnt_onehot0: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(gnt_o));

    a_valid_gnt: assert property (@(posedge clk_i) disable iff (!rst_ni)
        valid_o == (|gnt_o));

    a_stall_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (valid_o && !ready_i) |=> (valid_o && $stable(gnt_o) && $stable(idx_o)));
`endif

endmodule
